unidade_controle_rodadas: RTL and testbench

Moore control unit for the multi-round memory game. Each round N, the player must repeat plays 0..N; after the last round the game is won. It drives the play counter, round counter, play register and play timer in the datapath. It keeps an internal lives counter: a wrong play costs one life and restarts the current round. An optional timeout mode ends the game on player inactivity.

---
 rtl/unidade_controle_rodadas.sv | 147 ++++++++++++++
 tb/tb_unidade_controle_rodadas.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_rodadas.sv
// Moore control unit for the multi-round memory game: sequences plays and rounds,
// keeps the lives counter and reports win / loss / timeout.
module unidade_controle_rodadas #(
   parameter int unsigned VIDAS      = 3,
   parameter bit          TIMEOUT_EN = 1'b1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       jogada,
   input  logic       igual,
   input  logic       fimE,
   input  logic       fimR,
   input  logic       timeout,
   output logic       zeraE,
   output logic       contaE,
   output logic       zeraR,
   output logic       contaR,
   output logic       zeraReg,
   output logic       registraR,
   output logic       zeraT,
   output logic       pronto,
   output logic       acertou,
   output logic       errou,
   output logic       db_timeout,
   output logic [3:0] vidas,
   output logic [3:0] db_estado
);

   typedef enum logic [3:0] {
      Inicial       = 4'h0,
      Preparacao    = 4'h1,
      IniciaRodada  = 4'h2,
      Espera        = 4'h3,
      Registra      = 4'h4,
      Comparacao    = 4'h5,
      ProximaJogada = 4'h6,
      ProximaRodada = 4'h7,
      ErroJogada    = 4'h8,
      Tout          = 4'hB,
      Vitoria       = 4'hD,
      Derrota       = 4'hE
   } estado_t;

   localparam logic [3:0] VidasIni = 4'(VIDAS);

   estado_t    estado_q, estado_d;
   logic [3:0] vidas_q, vidas_d;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado_q <= Inicial;
         vidas_q  <= VidasIni;
      end else begin
         estado_q <= estado_d;
         vidas_q  <= vidas_d;
      end
   end

   always_comb begin
      estado_d   = estado_q;
      vidas_d    = vidas_q;
      zeraE      = 1'b0;
      contaE     = 1'b0;
      zeraR      = 1'b0;
      contaR     = 1'b0;
      zeraReg    = 1'b0;
      registraR  = 1'b0;
      zeraT      = 1'b0;
      pronto     = 1'b0;
      acertou    = 1'b0;
      errou      = 1'b0;
      db_timeout = 1'b0;
      db_estado  = estado_q;
      case (estado_q)
         Inicial: begin
            zeraE   = 1'b1;
            zeraR   = 1'b1;
            zeraReg = 1'b1;
            if (iniciar) begin
               estado_d = Preparacao;
               vidas_d  = VidasIni;
            end
         end
         Preparacao: begin
            zeraE    = 1'b1;
            zeraR    = 1'b1;
            zeraReg  = 1'b1;
            zeraT    = 1'b1;
            vidas_d  = VidasIni;
            estado_d = IniciaRodada;
         end
         IniciaRodada: begin
            zeraE    = 1'b1;
            zeraT    = 1'b1;
            estado_d = Espera;
         end
         Espera: begin
            // Inactivity wins over a simultaneous play.
            if (timeout && TIMEOUT_EN) estado_d = Tout;
            else if (jogada)           estado_d = Registra;
         end
         Registra: begin
            registraR = 1'b1;
            estado_d  = Comparacao;
         end
         Comparacao: begin
            if (!igual)            estado_d = ErroJogada;
            else if (fimE && fimR) estado_d = Vitoria;
            else if (fimE)         estado_d = ProximaRodada;
            else                   estado_d = ProximaJogada;
         end
         ProximaJogada: begin
            contaE   = 1'b1;
            zeraT    = 1'b1;
            estado_d = Espera;
         end
         ProximaRodada: begin
            contaR   = 1'b1;
            estado_d = IniciaRodada;
         end
         ErroJogada: begin
            // Decision uses the value before this edge's decrement.
            if (vidas_q == 4'd1) estado_d = Derrota;
            else                 estado_d = IniciaRodada;
            if (vidas_q != 4'd0) vidas_d = vidas_q - 4'd1;
         end
         Tout, Vitoria, Derrota: begin
            pronto     = 1'b1;
            acertou    = (estado_q == Vitoria);
            errou      = (estado_q != Vitoria);
            db_timeout = (estado_q == Tout);
            if (iniciar) begin
               estado_d = Preparacao;
               vidas_d  = VidasIni;
            end
         end
         default: begin
            db_estado = 4'hF;
            estado_d  = Inicial;
         end
      endcase
   end

   assign vidas = vidas_q;

endmodule

// File: tb/tb_unidade_controle_rodadas.sv
// Bench for unidade_controle_rodadas: dut_a (VIDAS=3, timeout on) and dut_b (VIDAS=1,
// timeout off) share stimulus; a small datapath model answers igual/fimE/fimR.
module tb_unidade_controle_rodadas;

   localparam int unsigned NR = 2;

   logic clock = 1'b0;
   logic reset, iniciar, jogada, igual, fimE, fimR, timeout, bad;

   logic zeraE_a, contaE_a, zeraR_a, contaR_a, zeraReg_a, registraR_a, zeraT_a;
   logic pronto_a, acertou_a, errou_a, db_timeout_a;
   logic [3:0] vidas_a, db_estado_a;
   logic zeraE_b, contaE_b, zeraR_b, contaR_b, zeraReg_b, registraR_b, zeraT_b;
   logic pronto_b, acertou_b, errou_b, db_timeout_b;
   logic [3:0] vidas_b, db_estado_b;

   logic [1:0] e, r;
   int conta_r_n;
   int nvec = 0;
   int nerr = 0;
   logic [7:0] exp_q[$];
   logic [7:0] obs_q[$];

   always #5 clock = ~clock;

   unidade_controle_rodadas #(.VIDAS(3), .TIMEOUT_EN(1'b1)) dut_a (
      .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada), .igual(igual),
      .fimE(fimE), .fimR(fimR), .timeout(timeout), .zeraE(zeraE_a), .contaE(contaE_a),
      .zeraR(zeraR_a), .contaR(contaR_a), .zeraReg(zeraReg_a), .registraR(registraR_a),
      .zeraT(zeraT_a), .pronto(pronto_a), .acertou(acertou_a), .errou(errou_a),
      .db_timeout(db_timeout_a), .vidas(vidas_a), .db_estado(db_estado_a)
   );

   unidade_controle_rodadas #(.VIDAS(1), .TIMEOUT_EN(1'b0)) dut_b (
      .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada), .igual(igual),
      .fimE(fimE), .fimR(fimR), .timeout(timeout), .zeraE(zeraE_b), .contaE(contaE_b),
      .zeraR(zeraR_b), .contaR(contaR_b), .zeraReg(zeraReg_b), .registraR(registraR_b),
      .zeraT(zeraT_b), .pronto(pronto_b), .acertou(acertou_b), .errou(errou_b),
      .db_timeout(db_timeout_b), .vidas(vidas_b), .db_estado(db_estado_b)
   );

   // Datapath model: play/round counters steered by dut_a's controls.
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         e <= 2'd0;
         r <= 2'd0;
      end else begin
         if (zeraE_a)       e <= 2'd0;
         else if (contaE_a) e <= e + 2'd1;
         if (zeraR_a)       r <= 2'd0;
         else if (contaR_a) r <= r + 2'd1;
         if (contaR_a) conta_r_n <= conta_r_n + 1;
      end
   end

   assign igual = ~bad;
   assign fimE  = (e == r);
   assign fimR  = (r == 2'(NR - 1));

   task automatic do_reset();
      iniciar = 1'b0; jogada = 1'b0; timeout = 1'b0; bad = 1'b0;
      reset = 1'b1;
      #3;
      reset = 1'b0;
   endtask

   task automatic cyc(input logic ini, input logic jog, input logic to, input logic bd,
                      input logic [3:0] ea, input logic [3:0] eb);
      iniciar = ini; jogada = jog; timeout = to; bad = bd;
      exp_q.push_back({ea, eb});
      @(posedge clock);
      #1;
      obs_q.push_back({db_estado_a, db_estado_b});
   endtask

   task automatic test_reset();
      logic [10:0] oa, ob;
      do_reset();
      reset = 1'b1;
      #1;
      oa = {zeraE_a, contaE_a, zeraR_a, contaR_a, zeraReg_a, registraR_a, zeraT_a,
            pronto_a, acertou_a, errou_a, db_timeout_a};
      ob = {zeraE_b, contaE_b, zeraR_b, contaR_b, zeraReg_b, registraR_b, zeraT_b,
            pronto_b, acertou_b, errou_b, db_timeout_b};
      nvec++; if (oa !== 11'b10101000000) begin nerr++; $display("FAIL reset_outs_a: got %b want %b", oa, 11'b10101000000); end
      nvec++; if (ob !== 11'b10101000000) begin nerr++; $display("FAIL reset_outs_b: got %b want %b", ob, 11'b10101000000); end
      nvec++; if ({db_estado_a, vidas_a} !== 8'h03) begin nerr++; $display("FAIL reset_a: got est %h vidas %0d want est 0 vidas 3", db_estado_a, vidas_a); end
      nvec++; if ({db_estado_b, vidas_b} !== 8'h01) begin nerr++; $display("FAIL reset_b: got est %h vidas %0d want est 0 vidas 1", db_estado_b, vidas_b); end
      #1;
      reset = 1'b0;
   endtask

   task automatic test_win();
      logic [7:0] ex, ob;
      int n = 0;
      do_reset();
      cyc(1,0,0,0, 4'h1,4'h1); cyc(0,0,0,0, 4'h2,4'h2); cyc(0,0,0,0, 4'h3,4'h3);
      cyc(0,1,0,0, 4'h4,4'h4);
      nvec++; if (registraR_a !== 1'b1) begin nerr++; $display("FAIL win_registraR: got %b want 1", registraR_a); end
      cyc(0,0,0,0, 4'h5,4'h5); cyc(0,0,0,0, 4'h7,4'h7);
      nvec++; if (contaR_a !== 1'b1) begin nerr++; $display("FAIL win_contaR: got %b want 1", contaR_a); end
      cyc(0,0,0,0, 4'h2,4'h2); cyc(0,0,0,0, 4'h3,4'h3);
      cyc(0,1,0,0, 4'h4,4'h4); cyc(0,0,0,0, 4'h5,4'h5); cyc(0,0,0,0, 4'h6,4'h6);
      nvec++; if ({contaE_a, zeraT_a} !== 2'b11) begin nerr++; $display("FAIL win_contaE_zeraT: got %b want 11", {contaE_a, zeraT_a}); end
      cyc(0,0,0,0, 4'h3,4'h3);
      cyc(0,1,0,0, 4'h4,4'h4); cyc(0,0,0,0, 4'h5,4'h5); cyc(0,0,0,0, 4'hD,4'hD);
      cyc(0,0,0,0, 4'hD,4'hD);
      while (exp_q.size() > 0) begin
         ex = exp_q.pop_front(); ob = obs_q.pop_front(); nvec++; n++;
         if (ob !== ex) begin nerr++; $display("FAIL win_seq step %0d: got a=%h b=%h want a=%h b=%h", n, ob[7:4], ob[3:0], ex[7:4], ex[3:0]); end
      end
      nvec++; if ({acertou_a, pronto_a, errou_a, vidas_a} !== 7'b1100011) begin nerr++; $display("FAIL win_flags: got acertou %b pronto %b errou %b vidas %0d want 1 1 0 3", acertou_a, pronto_a, errou_a, vidas_a); end
   endtask

   task automatic test_lives();
      logic [7:0] ex, ob;
      int n = 0;
      int c0;
      do_reset();
      c0 = conta_r_n;
      cyc(1,0,0,0, 4'h1,4'h1); cyc(0,0,0,0, 4'h2,4'h2); cyc(0,0,0,0, 4'h3,4'h3);
      cyc(0,1,0,0, 4'h4,4'h4); cyc(0,0,0,0, 4'h5,4'h5); cyc(0,0,0,0, 4'h7,4'h7);
      cyc(0,0,0,0, 4'h2,4'h2); cyc(0,0,0,0, 4'h3,4'h3);
      cyc(0,1,0,1, 4'h4,4'h4); cyc(0,0,0,1, 4'h5,4'h5); cyc(0,0,0,1, 4'h8,4'h8);
      cyc(0,0,0,0, 4'h2,4'hE);
      nvec++; if (vidas_a !== 4'd2) begin nerr++; $display("FAIL lives_first: got %0d want 2", vidas_a); end
      cyc(0,0,0,0, 4'h3,4'hE);
      cyc(0,1,0,1, 4'h4,4'hE); cyc(0,0,0,1, 4'h5,4'hE); cyc(0,0,0,1, 4'h8,4'hE);
      cyc(0,0,0,0, 4'h2,4'hE);
      nvec++; if (vidas_a !== 4'd1) begin nerr++; $display("FAIL lives_second: got %0d want 1", vidas_a); end
      cyc(0,0,0,0, 4'h3,4'hE);
      cyc(0,1,0,0, 4'h4,4'hE); cyc(0,0,0,0, 4'h5,4'hE); cyc(0,0,0,0, 4'h6,4'hE);
      cyc(0,0,0,0, 4'h3,4'hE);
      cyc(0,1,0,0, 4'h4,4'hE); cyc(0,0,0,0, 4'h5,4'hE); cyc(0,0,0,0, 4'hD,4'hE);
      while (exp_q.size() > 0) begin
         ex = exp_q.pop_front(); ob = obs_q.pop_front(); nvec++; n++;
         if (ob !== ex) begin nerr++; $display("FAIL lives_seq step %0d: got a=%h b=%h want a=%h b=%h", n, ob[7:4], ob[3:0], ex[7:4], ex[3:0]); end
      end
      nvec++; if ({acertou_a, vidas_a} !== 5'b10001) begin nerr++; $display("FAIL lives_end: got acertou %b vidas %0d want 1 1", acertou_a, vidas_a); end
      nvec++; if (r !== 2'd1 || (conta_r_n - c0) !== 1) begin nerr++; $display("FAIL lives_round: got r %0d contaR %0d want r 1 contaR 1", r, conta_r_n - c0); end
   endtask

   task automatic test_timeout();
      logic [7:0] ex, ob;
      int n = 0;
      do_reset();
      cyc(1,0,0,0, 4'h1,4'h1); cyc(0,0,0,0, 4'h2,4'h2); cyc(0,0,0,0, 4'h3,4'h3);
      cyc(0,1,1,0, 4'hB,4'h4); cyc(0,0,1,0, 4'hB,4'h5); cyc(0,0,0,0, 4'hB,4'h7);
      while (exp_q.size() > 0) begin
         ex = exp_q.pop_front(); ob = obs_q.pop_front(); nvec++; n++;
         if (ob !== ex) begin nerr++; $display("FAIL timeout_seq step %0d: got a=%h b=%h want a=%h b=%h", n, ob[7:4], ob[3:0], ex[7:4], ex[3:0]); end
      end
      nvec++; if ({db_timeout_a, errou_a, pronto_a, acertou_a} !== 4'b1110) begin nerr++; $display("FAIL timeout_flags: got %b want 1110", {db_timeout_a, errou_a, pronto_a, acertou_a}); end
   endtask

   task automatic test_loss_restart();
      logic [7:0] ex, ob;
      int n = 0;
      do_reset();
      cyc(1,0,0,0, 4'h1,4'h1); cyc(0,0,0,0, 4'h2,4'h2); cyc(0,0,0,0, 4'h3,4'h3);
      cyc(0,1,0,1, 4'h4,4'h4); cyc(0,0,0,1, 4'h5,4'h5); cyc(0,0,0,1, 4'h8,4'h8);
      cyc(0,0,0,0, 4'h2,4'hE);
      nvec++; if ({errou_b, pronto_b, acertou_b, vidas_b} !== 7'b1100000) begin nerr++; $display("FAIL loss_flags: got errou %b pronto %b acertou %b vidas %0d want 1 1 0 0", errou_b, pronto_b, acertou_b, vidas_b); end
      cyc(0,0,0,0, 4'h3,4'hE);
      // iniciar is honoured by dut_b (derrota) but ignored by dut_a (espera).
      cyc(1,0,0,0, 4'h3,4'h1);
      nvec++; if ({zeraR_b, zeraE_b, zeraReg_b, zeraT_b, pronto_b} !== 5'b11110) begin nerr++; $display("FAIL restart_zera: got %b want 11110", {zeraR_b, zeraE_b, zeraReg_b, zeraT_b, pronto_b}); end
      cyc(1,0,0,0, 4'h3,4'h2);
      nvec++; if (vidas_b !== 4'd1 || vidas_a !== 4'd2) begin nerr++; $display("FAIL restart_vidas: got b %0d a %0d want b 1 a 2", vidas_b, vidas_a); end
      cyc(0,0,0,0, 4'h3,4'h3);
      while (exp_q.size() > 0) begin
         ex = exp_q.pop_front(); ob = obs_q.pop_front(); nvec++; n++;
         if (ob !== ex) begin nerr++; $display("FAIL loss_seq step %0d: got a=%h b=%h want a=%h b=%h", n, ob[7:4], ob[3:0], ex[7:4], ex[3:0]); end
      end
   endtask

   task automatic test_async_reset();
      logic [7:0] ex, ob;
      int n = 0;
      do_reset();
      cyc(1,0,0,0, 4'h1,4'h1); cyc(0,0,0,0, 4'h2,4'h2); cyc(0,0,0,0, 4'h3,4'h3);
      for (int k = 0; k < 2; k++) begin
         cyc(0,1,0,1, 4'h4, (k == 0) ? 4'h4 : 4'hE);
         cyc(0,0,0,1, 4'h5, (k == 0) ? 4'h5 : 4'hE);
         cyc(0,0,0,1, 4'h8, (k == 0) ? 4'h8 : 4'hE);
         cyc(0,0,0,0, 4'h2, 4'hE);
         cyc(0,0,0,0, 4'h3, 4'hE);
      end
      cyc(0,1,0,0, 4'h4,4'hE); cyc(0,0,0,0, 4'h5,4'hE);
      while (exp_q.size() > 0) begin
         ex = exp_q.pop_front(); ob = obs_q.pop_front(); nvec++; n++;
         if (ob !== ex) begin nerr++; $display("FAIL areset_seq step %0d: got a=%h b=%h want a=%h b=%h", n, ob[7:4], ob[3:0], ex[7:4], ex[3:0]); end
      end
      nvec++; if (vidas_a !== 4'd1) begin nerr++; $display("FAIL areset_pre: got vidas %0d want 1", vidas_a); end
      #1;
      reset = 1'b1;
      #1;
      nvec++; if ({db_estado_a, vidas_a} !== 8'h03) begin nerr++; $display("FAIL areset_a: got est %h vidas %0d want est 0 vidas 3", db_estado_a, vidas_a); end
      nvec++; if ({db_estado_b, vidas_b} !== 8'h01) begin nerr++; $display("FAIL areset_b: got est %h vidas %0d want est 0 vidas 1", db_estado_b, vidas_b); end
      #1;
      reset = 1'b0;
   endtask

   initial begin
      conta_r_n = 0;
      test_reset();
      test_win();
      test_lives();
      test_timeout();
      test_loss_restart();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
